// File: rtl/serv_rf_ram_clr.sv
`default_nettype none
// ============================================================================
// Module      : serv_rf_ram_clr
// Description : Register-file storage for SERV. Single write port and single
//               registered read port over depth words of width+1 bits; the
//               extra bit is an even-parity bit over the data. After every
//               reset a hardware sweep clears the whole array to zero before
//               o_init_done is raised. Read-side parity mismatches set a
//               sticky error flag.
// Ports       : i_clk, i_rst        clock, synchronous active-high reset
//               o_init_done         high once the clear sweep has finished
//               i_waddr/i_wdata/i_wen/i_perr_inj   write port (+ parity inject)
//               i_raddr/o_rdata     read port, one cycle latency, read-first
//               o_perr/i_perr_clr   sticky parity error flag and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module serv_rf_ram_clr #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int depth    = 32 * (32 + csr_regs) / width
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_init_done,
    input  logic [$clog2(depth)-1:0] i_waddr,
    input  logic [width-1:0]         i_wdata,
    input  logic                     i_wen,
    input  logic                     i_perr_inj,
    input  logic [$clog2(depth)-1:0] i_raddr,
    output logic [width-1:0]         o_rdata,
    output logic                     o_perr,
    input  logic                     i_perr_clr
);

    localparam int c_aw = $clog2(depth);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_aw-1:0]   r_clr_cnt;
    logic [c_aw-1:0]   w_clr_cnt_nxt;

    logic [width:0]    r_mem [depth];

    logic              w_mem_we;
    logic [c_aw-1:0]   w_mem_addr;
    logic [width:0]    w_mem_wdata;
    logic              w_rd_en;

    logic [width-1:0]  r_rdata;
    logic              r_rpar;
    logic              r_rvalid;
    logic              r_perr;

    // Depth need not be a power of two, so both ports range-check.
    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_par_mis;

    assign w_waddr_ok = (32'(i_waddr) < depth);
    assign w_raddr_ok = (32'(i_raddr) < depth);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and write-port steering
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_mem_we      = 1'b0;
        w_mem_addr    = i_waddr;
        w_mem_wdata   = {^i_wdata ^ i_perr_inj, i_wdata};
        w_rd_en       = 1'b0;

        case (r_state)
            S_INIT: begin
                // Sweep owns the write port; external writes are ignored.
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_cnt;
                w_mem_wdata   = '0;
                w_clr_cnt_nxt = r_clr_cnt + c_aw'(1);
                if (32'(r_clr_cnt) == depth - 1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_mem_we = i_wen && w_waddr_ok;
                w_rd_en  = 1'b1;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array: contents are left untouched while reset is held.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port. Reading the array with a non-blocking update
    // alongside the write gives read-first behaviour on an address clash.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= '0;
            r_rpar   <= 1'b0;
            r_rvalid <= 1'b0;
        end else if (w_rd_en && w_raddr_ok) begin
            r_rdata  <= r_mem[i_raddr][width-1:0];
            r_rpar   <= r_mem[i_raddr][width];
            r_rvalid <= 1'b1;
        end else begin
            r_rdata  <= '0;
            r_rpar   <= 1'b0;
            r_rvalid <= 1'b0;
        end
    end

    // Parity of the word currently on o_rdata is checked one cycle later,
    // keeping the XOR tree off the array read path.
    assign w_par_mis = r_rvalid && (r_rpar != ^r_rdata);

    // A mismatch wins over a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perr <= 1'b0;
        end else if (w_par_mis) begin
            r_perr <= 1'b1;
        end else if (i_perr_clr) begin
            r_perr <= 1'b0;
        end
    end

    assign o_init_done = (r_state == S_RUN);
    assign o_rdata     = r_rdata;
    assign o_perr      = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_serv_rf_ram_clr
// Description : Self-checking bench for serv_rf_ram_clr (width=8, csr_regs=4,
//               depth=144). A behavioural model tracks array contents as
//               data plus a "corrupted" flag per word and is compared with
//               the DUT after every clock edge; fixed vectors and directed
//               sequences cover the sweep, read-first, parity and range cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_rf_ram_clr;

    localparam int W   = 8;
    localparam int CSR = 4;
    localparam int D   = 144;
    localparam int AW  = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          o_init_done;
    logic [AW-1:0] i_waddr;
    logic [W-1:0]  i_wdata;
    logic          i_wen;
    logic          i_perr_inj;
    logic [AW-1:0] i_raddr;
    logic [W-1:0]  o_rdata;
    logic          o_perr;
    logic          i_perr_clr;

    always #5 i_clk = ~i_clk;

    serv_rf_ram_clr #(
        .width    (W),
        .csr_regs (CSR)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_init_done (o_init_done),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_wen       (i_wen),
        .i_perr_inj  (i_perr_inj),
        .i_raddr     (i_raddr),
        .o_rdata     (o_rdata),
        .o_perr      (o_perr),
        .i_perr_clr  (i_perr_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_data [D];
    bit           m_bad  [D];
    int           m_cyc = 0;     // edges since reset release
    logic [W-1:0] m_rdata = '0;
    bit           m_perr = 1'b0;
    bit           m_pend = 1'b0; // word on o_rdata carries bad parity

    task automatic model_edge();
        if (i_rst) begin
            m_cyc   = 0;
            m_rdata = '0;
            m_perr  = 1'b0;
            m_pend  = 1'b0;
        end else if (m_cyc < D) begin
            m_data[m_cyc] = '0;
            m_bad[m_cyc]  = 1'b0;
            m_cyc++;
            m_rdata = '0;
            m_pend  = 1'b0;
            m_perr  = m_perr && !i_perr_clr;
        end else begin
            if (m_pend)          m_perr = 1'b1;
            else if (i_perr_clr) m_perr = 1'b0;
            if (int'(i_raddr) < D) begin
                m_rdata = m_data[i_raddr];
                m_pend  = m_bad[i_raddr];
            end else begin
                m_rdata = '0;
                m_pend  = 1'b0;
            end
            if (i_wen && int'(i_waddr) < D) begin
                m_data[i_waddr] = i_wdata;
                m_bad[i_waddr]  = i_perr_inj;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
        chk("model_rdata", 32'(o_rdata), 32'(m_rdata));
        chk("model_perr", 32'(o_perr), 32'(m_perr));
        chk("model_init_done", 32'(o_init_done), 32'(m_cyc >= D));
    endtask

    task automatic set_idle();
        i_wen      = 1'b0;
        i_waddr    = '0;
        i_wdata    = '0;
        i_perr_inj = 1'b0;
        i_perr_clr = 1'b0;
        i_raddr    = '0;
    endtask

    // Counts edges after release until o_init_done is seen (bounded).
    task automatic wait_init(output int n);
        n = 0;
        do begin
            if (i_wen) begin
                i_waddr = AW'($urandom_range(0, D - 1));
                i_wdata = W'($urandom);
            end
            tick();
            n++;
        end while (!o_init_done && n < 300);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         wen;
        logic [7:0]   waddr;
        logic [7:0]   wdata;
        logic         inj;
        logic         clr;
        logic [7:0]   raddr;
        logic [7:0]   exp_rdata;
        logic         exp_perr;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [7:0] waddr, input logic [7:0] wdata,
                                input logic inj, input logic clr, input logic [7:0] raddr,
                                input logic [7:0] exp_rdata, input logic exp_perr);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.inj = inj; v.clr = clr;
        v.raddr = raddr; v.exp_rdata = exp_rdata; v.exp_perr = exp_perr;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        int n;

        tbl[0]  = mk(1'b1, 8'd10,  8'hA5, 1'b0, 1'b0, 8'd0,   8'h00, 1'b0);
        tbl[1]  = mk(1'b1, 8'd143, 8'h3C, 1'b0, 1'b0, 8'd10,  8'hA5, 1'b0);
        tbl[2]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd143, 8'h3C, 1'b0);
        tbl[3]  = mk(1'b1, 8'd5,   8'h11, 1'b0, 1'b0, 8'd5,   8'h00, 1'b0);
        tbl[4]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd5,   8'h11, 1'b0);
        tbl[5]  = mk(1'b1, 8'd20,  8'h5A, 1'b1, 1'b0, 8'd0,   8'h00, 1'b0);
        tbl[6]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd20,  8'h5A, 1'b0);
        tbl[7]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd0,   8'h00, 1'b1);
        tbl[8]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd0,   8'h00, 1'b1);
        tbl[9]  = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h00, 1'b0);
        tbl[10] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd20,  8'h5A, 1'b0);
        tbl[11] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd20,  8'h5A, 1'b1);
        tbl[12] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h00, 1'b1);
        tbl[13] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b1, 8'd0,   8'h00, 1'b0);
        tbl[14] = mk(1'b1, 8'd150, 8'hFF, 1'b0, 1'b0, 8'd150, 8'h00, 1'b0);
        tbl[15] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd150, 8'h00, 1'b0);
        tbl[16] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd6,   8'h00, 1'b0);
        tbl[17] = mk(1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'd143, 8'h3C, 1'b0);

        // ---- reset, sweep, fill with garbage, reset again ----
        set_idle();
        i_rst = 1'b1;
        tick();
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_perr", 32'(o_perr), 32'd0);
        tick();
        i_rst = 1'b0;
        wait_init(n);
        chk("init_latency_first", 32'(n), 32'd144);

        i_raddr = 8'd150;
        for (int a = 0; a < D; a++) begin
            i_wen      = 1'b1;
            i_waddr    = AW'(a);
            i_wdata    = W'($urandom);
            i_perr_inj = 1'($urandom_range(0, 1));
            tick();
        end
        set_idle();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        wait_init(n);
        chk("init_latency_garbage", 32'(n), 32'd144);

        i_raddr = 8'd0;   tick(); chk("clr_rd0",   32'(o_rdata), 32'd0);
        i_raddr = 8'd77;  tick(); chk("clr_rd77",  32'(o_rdata), 32'd0);
        i_raddr = 8'd143; tick(); chk("clr_rd143", 32'(o_rdata), 32'd0);
        i_raddr = 8'd0;   tick(); chk("clr_perr",  32'(o_perr),  32'd0);

        // ---- fixed vectors ----
        for (int i = 0; i < 18; i++) begin
            i_wen      = tbl[i].wen;
            i_waddr    = tbl[i].waddr;
            i_wdata    = tbl[i].wdata;
            i_perr_inj = tbl[i].inj;
            i_perr_clr = tbl[i].clr;
            i_raddr    = tbl[i].raddr;
            tick();
            chk($sformatf("vec%0d_rdata", i), 32'(o_rdata), 32'(tbl[i].exp_rdata));
            chk($sformatf("vec%0d_perr", i),  32'(o_perr),  32'(tbl[i].exp_perr));
        end
        set_idle();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            i_rst      = ($urandom_range(0, 399) == 0);
            i_wen      = 1'($urandom_range(0, 1));
            i_waddr    = AW'($urandom_range(0, 159));
            i_wdata    = W'($urandom);
            i_perr_inj = ($urandom_range(0, 15) == 0);
            i_perr_clr = ($urandom_range(0, 7) == 0);
            i_raddr    = AW'($urandom_range(0, 159));
            tick();
        end
        set_idle();
        i_rst = 1'b0;

        // ---- reset in the middle of the sweep, with writes during INIT ----
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_wen = 1'b1;
        for (int c = 0; c < 60; c++) begin
            i_waddr = AW'($urandom_range(0, D - 1));
            i_wdata = W'($urandom) | 8'h01;
            tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        wait_init(n);
        chk("init_latency_restart", 32'(n), 32'd144);
        set_idle();
        for (int a = 0; a < D; a++) begin
            i_raddr = AW'(a);
            tick();
            chk($sformatf("restart_rd%0d", a), 32'(o_rdata), 32'd0);
        end
        chk("restart_perr", 32'(o_perr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
